// File: rtl/imem_pkg.sv
// Shared types and default parameters for the loadable instruction memory.
// Optional parity protection is enabled with IMEM_PARITY_EN.
package imem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN
  } state_e;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 16;
  localparam int DEPTH_DEF  = 64;

  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

endpackage

// File: rtl/imem_array.sv
// Unreset storage array: synchronous write port, synchronous read port.
// Read data holds its value when no read is enabled.
module imem_array #(
  parameter int W  = 32,
  parameter int D  = 64,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [D];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_loadable.sv
// Instruction memory loaded word-by-word, then fetched one word per cycle.
// Define IMEM_PARITY_EN to store and check one even-parity bit per word.
module imem_loadable
  import imem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEF),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              LoadStart,
  input  logic              LoadWe,
  input  logic [DATA_W-1:0] LoadData,
  input  logic              LoadDone,
  input  logic              FetchReq,
  input  logic [ADDR_W-1:0] PC,
  output logic              FetchReady,
  output logic [DATA_W-1:0] Instruction,
  output logic              InstrValid,
  output logic              AddrFault,
`ifdef IMEM_PARITY_EN
  output logic              ParityErr,
`endif
  output logic [CNT_W-1:0]  LoadCount,
  output logic              LoadOverflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef IMEM_PARITY_EN
  localparam int MW = DATA_W + 1;
`else
  localparam int MW = DATA_W;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             vld_q, flt_q, have_q;
  logic             loading, full, wr_en, fire, in_rng;
  logic [MW-1:0]    wdata, rdata;

  // A LoadStart overrides any other load activity in the same cycle
  assign loading = (state_q == ST_LOAD) && !LoadStart;
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign wr_en   = loading && LoadWe && !full;
  assign fire    = FetchReq && FetchReady;
  assign in_rng  = 64'(PC) < 64'(cnt_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (1'b1)
      LoadStart: begin
        state_d = ST_LOAD;
        cnt_d   = '0;
        ovf_d   = 1'b0;
      end
      loading: begin
        if (LoadWe) begin
          if (full) ovf_d = 1'b1;
          else      cnt_d = cnt_q + 1'b1;
        end
        if (LoadDone) state_d = ST_RUN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
      flt_q   <= 1'b0;
      have_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      vld_q   <= fire;
      if (fire) begin
        flt_q  <= !in_rng;
        have_q <= 1'b1;
      end
    end
  end

`ifdef IMEM_PARITY_EN
  assign wdata     = {^LoadData, LoadData};
  assign ParityErr = vld_q && !flt_q && (^rdata);
`else
  assign wdata     = LoadData;
`endif

  imem_array #(
    .W  (MW),
    .D  (DEPTH),
    .AW (AW)
  ) u_arr (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (cnt_q[AW-1:0]),
    .wdata_i (wdata),
    .re_i    (fire && in_rng),
    .raddr_i (PC[AW-1:0]),
    .rdata_o (rdata)
  );

  // The array has no reset, so show NOP until a real word has been read
  assign Instruction  = (have_q && !flt_q) ? rdata[DATA_W-1:0] : NOP_WORD;
  assign InstrValid   = vld_q;
  assign AddrFault    = flt_q;
  assign FetchReady   = (state_q == ST_RUN);
  assign LoadCount    = cnt_q;
  assign LoadOverflow = ovf_q;

endmodule

// File: tb/tb_imem_loadable.sv
// Directed checks of load, fetch, fault, overflow and reset behaviour.
// Parity checks are included when IMEM_PARITY_EN is defined.
module tb_imem_loadable;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          LoadStart = 1'b0;
  logic          LoadWe = 1'b0;
  logic [DW-1:0] LoadData = '0;
  logic          LoadDone = 1'b0;
  logic          FetchReq = 1'b0;
  logic [AW-1:0] PC = '0;
  logic          FetchReady;
  logic [DW-1:0] Instruction;
  logic          InstrValid;
  logic          AddrFault;
  logic [2:0]    LoadCount;
  logic          LoadOverflow;
`ifdef IMEM_PARITY_EN
  logic          ParityErr;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] w4 [4];

  imem_loadable #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .DEPTH  (DP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .LoadStart    (LoadStart),
    .LoadWe       (LoadWe),
    .LoadData     (LoadData),
    .LoadDone     (LoadDone),
    .FetchReq     (FetchReq),
    .PC           (PC),
    .FetchReady   (FetchReady),
    .Instruction  (Instruction),
    .InstrValid   (InstrValid),
    .AddrFault    (AddrFault),
`ifdef IMEM_PARITY_EN
    .ParityErr    (ParityErr),
`endif
    .LoadCount    (LoadCount),
    .LoadOverflow (LoadOverflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [DW-1:0] d, input logic done);
    LoadWe   = 1'b1;
    LoadData = d;
    LoadDone = done;
    step();
    LoadWe   = 1'b0;
    LoadDone = 1'b0;
  endtask

  task automatic start();
    LoadStart = 1'b1;
    step();
    LoadStart = 1'b0;
  endtask

  task automatic fetch1(input logic [AW-1:0] pc);
    FetchReq = 1'b1;
    PC       = pc;
    step();
    FetchReq = 1'b0;
  endtask

  initial begin
    w4[0] = 32'h1111_0001;
    w4[1] = 32'h2222_0002;
    w4[2] = 32'h3333_0003;
    w4[3] = 32'h4444_0004;

    #2;
    chk("rst_ready", FetchReady, 0);
    chk("rst_valid", InstrValid, 0);
    chk("rst_fault", AddrFault, 0);
    chk("rst_instr", Instruction, 0);
    chk("rst_count", LoadCount, 0);
    chk("rst_ovf", LoadOverflow, 0);
    step();
    rst_n = 1'b1;
    step();

    fetch1(16'd0);
    chk("idle_valid", InstrValid, 0);
    chk("idle_ready", FetchReady, 0);

    start();
    chk("load_count0", LoadCount, 0);
    chk("load_ready", FetchReady, 0);
    fetch1(16'd0);
    chk("load_fetch_valid", InstrValid, 0);
    wr(32'h0000_0000, 1'b0);
    wr(32'hC821_0005, 1'b0);
    wr(32'hC842_000A, 1'b1);
    chk("load3_count", LoadCount, 3);
    chk("run_ready", FetchReady, 1);

    fetch1(16'd1);
    chk("pc1_instr", Instruction, 32'hC821_0005);
    chk("pc1_valid", InstrValid, 1);
    chk("pc1_fault", AddrFault, 0);
    step();
    chk("hold_valid", InstrValid, 0);
    chk("hold_instr", Instruction, 32'hC821_0005);

    fetch1(16'd3);
    chk("pc3_instr", Instruction, 0);
    chk("pc3_valid", InstrValid, 1);
    chk("pc3_fault", AddrFault, 1);

    FetchReq = 1'b1;
    PC = 16'd2;
    step();
    PC = 16'h8001;
    chk("b2b_pc2_instr", Instruction, 32'hC842_000A);
    chk("b2b_pc2_fault", AddrFault, 0);
    step();
    FetchReq = 1'b0;
    chk("far_pc_valid", InstrValid, 1);
    chk("far_pc_fault", AddrFault, 1);
    chk("far_pc_instr", Instruction, 0);

    start();
    for (int i = 0; i < 4; i++) wr(w4[i], 1'b0);
    wr(32'hDEAD_BEEF, 1'b0);
    chk("ovf_count", LoadCount, 4);
    chk("ovf_flag", LoadOverflow, 1);
    LoadDone = 1'b1;
    step();
    LoadDone = 1'b0;
    chk("ovf_run", FetchReady, 1);

    FetchReq = 1'b1;
    PC = 16'd0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 3) FetchReq = 1'b0;
      else PC = AW'(i + 1);
      chk("burst_valid", InstrValid, 1);
      chk("burst_instr", Instruction, w4[i]);
      chk("burst_fault", AddrFault, 0);
    end
    fetch1(16'd4);
    chk("pc4_fault", AddrFault, 1);

    LoadDone = 1'b1;
    LoadWe = 1'b1;
    LoadData = 32'hBAD0_BAD0;
    step();
    LoadDone = 1'b0;
    LoadWe = 1'b0;
    chk("run_done_ign", FetchReady, 1);
    chk("run_we_ign", LoadCount, 4);

    fetch1(16'd1);
    chk("pre_restart", Instruction, w4[1]);
    LoadStart = 1'b1;
    fetch1(16'd2);
    LoadStart = 1'b0;
    chk("restart_valid", InstrValid, 1);
    chk("restart_old", Instruction, w4[2]);
    chk("restart_ready", FetchReady, 0);
    chk("restart_ovf", LoadOverflow, 0);

    wr(32'hAAAA_5555, 1'b0);
    wr(32'h5555_AAAA, 1'b0);
    chk("mid_count", LoadCount, 2);
    rst_n = 1'b0;
    #1;
    chk("async_count", LoadCount, 0);
    chk("async_ready", FetchReady, 0);
    chk("async_instr", Instruction, 0);
    chk("async_valid", InstrValid, 0);
    chk("async_fault", AddrFault, 0);
    step();
    rst_n = 1'b1;
    step();
    LoadDone = 1'b1;
    step();
    LoadDone = 1'b0;
    chk("idle_done_ign", FetchReady, 0);
    fetch1(16'd0);
    chk("idle2_valid", InstrValid, 0);

`ifdef IMEM_PARITY_EN
    start();
    wr(32'h0000_0000, 1'b0);
    wr(32'hC821_0005, 1'b0);
    wr(32'hC842_000A, 1'b1);
    fetch1(16'd2);
    chk("par_clean", ParityErr, 0);
    dut.u_arr.mem_q[1][DW] = ~dut.u_arr.mem_q[1][DW];
    fetch1(16'd1);
    chk("par_valid", InstrValid, 1);
    chk("par_err", ParityErr, 1);
    chk("par_instr", Instruction, 32'hC821_0005);
    step();
    chk("par_drop", ParityErr, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imem_loadable.md
IMEM_LOADABLE -- requirements
Module: imem_loadable

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 16, PC width in bits, word-addressed.
REQ-003 SHALL have parameter DEPTH, default 64, number of instruction words stored.
REQ-004 SHALL have parameter NOP_WORD, default all-zero, word returned on any invalid fetch.
REQ-005 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port LoadStart, input, 1, begin a program load (pulse).
REQ-008 SHALL have port LoadWe, input, 1, write LoadData at the next load slot.
REQ-009 SHALL have port LoadData, input, DATA_W, program word to store.
REQ-010 SHALL have port LoadDone, input, 1, end the program load (pulse).
REQ-011 SHALL have port FetchReq, input, 1, fetch request.
REQ-012 SHALL have port PC, input, ADDR_W, word address of the requested instruction.
REQ-013 SHALL have port FetchReady, output, 1, high when a fetch can be accepted.
REQ-014 SHALL have port Instruction, output, DATA_W, fetched word (registered).
REQ-015 SHALL have port InstrValid, output, 1, one-cycle strobe marking Instruction as new.
REQ-016 SHALL have port AddrFault, output, 1, qualifies InstrValid: PC was at or beyond LoadCount.
REQ-017 SHALL have port LoadCount, output, clog2(DEPTH+1), number of words in the loaded program.
REQ-018 SHALL have port LoadOverflow, output, 1, sticky flag: a write was attempted with the memory full.

Function
REQ-019 SHALL implement states IDLE (no program), LOAD and RUN.
REQ-020 LoadStart in any state SHALL enter LOAD next cycle, clear LoadCount to 0 and clear LoadOverflow.
REQ-021 In LOAD, LoadWe SHALL write LoadData at address LoadCount and increment LoadCount by 1.
REQ-022 LoadWe with LoadCount==DEPTH SHALL write nothing and set LoadOverflow.
REQ-023 LoadDone in LOAD SHALL enter RUN next cycle; LoadWe in the same cycle is written first.
REQ-024 LoadStart and LoadDone together SHALL be treated as LoadStart; LoadDone outside LOAD and LoadWe outside LOAD SHALL be ignored.
REQ-025 FetchReady SHALL be 1 only in RUN.
REQ-026 A fetch is accepted when FetchReq and FetchReady are both 1 at a clock edge; one-cycle latency: InstrValid is 1 on the following cycle only.
REQ-027 Accepted fetch with PC < LoadCount SHALL return mem[PC] with AddrFault=0; otherwise NOP_WORD with AddrFault=1 (PC compared at full ADDR_W, no wrap).
REQ-028 Instruction SHALL hold its last value when no fetch is accepted.
REQ-029 Back-to-back accepted fetches SHALL sustain one word per cycle.
REQ-030 LoadStart in the same cycle as an accepted fetch SHALL let that fetch complete with the old contents.

Reset
REQ-031 rst_n low SHALL immediately force state IDLE, LoadCount 0, LoadOverflow 0, Instruction NOP_WORD, InstrValid 0, AddrFault 0, FetchReady 0.
REQ-032 The storage array SHALL NOT be reset; reset during LOAD SHALL abandon the load, and the program SHALL be reloaded.

Configuration
REQ-033 With macro IMEM_PARITY_EN defined, SHALL store one even-parity bit per word, check it on every in-range fetch, and drive output ParityErr (1 bit, reset 0) high alongside InstrValid on a mismatch, with Instruction still returned unmodified.
REQ-034 Without IMEM_PARITY_EN, SHALL have no parity storage and no ParityErr port.

Structure
REQ-035 Package imem_pkg SHALL hold the state enum, NOP_WORD default and default parameter values.
REQ-036 SHALL instantiate one sub-module imem_array: DEPTH x DATA_W (+1 with parity), synchronous write, synchronous read, no reset.

Verification
REQ-037 Reset, load 0x00000000, 0xC8210005, 0xC842000A, LoadDone, fetch PC=1 -> next cycle Instruction=0xC8210005, InstrValid=1, AddrFault=0.
REQ-038 Fetch PC=3 after the same 3-word load -> Instruction=0x00000000, AddrFault=1.
REQ-039 DEPTH=4, five LoadWe -> LoadCount=4, LoadOverflow=1; fetch PC=0..3 in consecutive cycles -> four consecutive InstrValid strobes with the first four words.
REQ-040 Fetch in LOAD or IDLE -> FetchReady=0, no InstrValid; LoadWe with LoadDone on the last word -> the word is stored and RUN is entered.
REQ-041 rst_n low mid-load after 2 writes -> outputs at reset values asynchronously, state IDLE, LoadCount=0.
REQ-042 With IMEM_PARITY_EN, force one stored parity bit to flip, then fetch that word -> ParityErr=1 with InstrValid=1.
